// File: rtl/muxpar_sched.sv
`default_nettype none
// ============================================================================
//  Module   : muxpar_sched
//  Purpose  : Round-robin frame scheduler. Grants one source for a whole
//             frame and emits {all-ones header, payload, sequence} words
//             through a single registered valid/ready output stage.
//  Revision : 1.0  initial release
// ============================================================================
module muxpar_sched #(
  parameter int BUS_SIZE  = 32,
  parameter int WORD_SIZE = 4,
  parameter int NUM_SRC   = 4,
  parameter int SRC_W     = 2
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_SRC-1:0]                          src_valid,
  input  logic [NUM_SRC*(BUS_SIZE-2*WORD_SIZE)-1:0]   src_data,
  input  logic [NUM_SRC-1:0]                          src_last,
  output logic [NUM_SRC-1:0]                          src_ready,
  output logic                                        out_valid,
  output logic [BUS_SIZE-1:0]                         out_data,
  input  logic                                        out_ready,
  output logic [SRC_W-1:0]                            grant_id,
  output logic                                        busy,
  output logic                                        trunc_err
);

  localparam int                   PAY_W   = BUS_SIZE - 2*WORD_SIZE;
  localparam logic [WORD_SIZE-1:0] MAX_SEQ = '1;
  localparam logic [WORD_SIZE-1:0] HDR     = '1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t               state_q;
  logic [SRC_W-1:0]     grant_q;
  logic [SRC_W-1:0]     ptr_q;
  logic [WORD_SIZE-1:0] seq_q;
  logic                 out_valid_q;
  logic [BUS_SIZE-1:0]  out_data_q;
  logic                 trunc_q;

  logic [PAY_W-1:0]     pay_w [NUM_SRC];
  logic                 can_take;
  logic                 accept;
  logic                 last_g;
  logic                 found_d;
  logic [SRC_W-1:0]     grant_d;

  // Slice the flat payload bus into one lane per source
  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
      assign pay_w[i] = src_data[PAY_W*i +: PAY_W];
    end
  endgenerate

  // The granted source may push whenever the output slot is free or draining
  assign can_take  = (state_q == ST_XFER) && (!out_valid_q || out_ready);
  assign accept    = can_take && src_valid[grant_q];
  assign last_g    = src_last[grant_q];
  assign src_ready = can_take ? (NUM_SRC'(1) << grant_q) : '0;

  // Round-robin search starting just after the last served source;
  // iterating from the far end lets the nearest requester win
  always_comb begin
    logic [SRC_W-1:0] idx;
    found_d = 1'b0;
    grant_d = '0;
    idx     = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = SRC_W'((int'(ptr_q) + k) % NUM_SRC);
      if (src_valid[idx]) begin
        found_d = 1'b1;
        grant_d = idx;
      end
    end
  end

  // Output stage: load on accept, otherwise drop valid once drained
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= {HDR, pay_w[grant_q], seq_q};
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Frame FSM: arbitrate in IDLE, count words and close frames in XFER
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      seq_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (found_d) begin
            grant_q <= grant_d;
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (accept) begin
            if (last_g || (seq_q == MAX_SEQ)) begin
              state_q <= ST_IDLE;
              ptr_q   <= grant_q;
              seq_q   <= '0;
              // Sequence space exhausted before the source ended its frame
              trunc_q <= (seq_q == MAX_SEQ) && !last_g;
            end else begin
              seq_q <= seq_q + WORD_SIZE'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == ST_XFER);
  assign trunc_err = trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_muxpar_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muxpar_sched
//  Purpose  : Self-checking bench for muxpar_sched against a frame-level
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muxpar_sched;
  localparam int BUS = 32;
  localparam int WS  = 4;
  localparam int NS  = 4;
  localparam int SW  = 2;
  localparam int PW  = BUS - 2*WS;

  logic              clk = 1'b0;
  logic              reset;
  logic [NS-1:0]     src_valid;
  logic [NS*PW-1:0]  src_data;
  logic [NS-1:0]     src_last;
  logic [NS-1:0]     src_ready;
  logic              out_valid;
  logic [BUS-1:0]    out_data;
  logic              out_ready;
  logic [SW-1:0]     grant_id;
  logic              busy;
  logic              trunc_err;

  muxpar_sched #(.BUS_SIZE(BUS), .WORD_SIZE(WS), .NUM_SRC(NS), .SRC_W(SW)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_ready(src_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .grant_id(grant_id),
    .busy(busy), .trunc_err(trunc_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: frame-level view (in a frame or not, which source,
  // how many words so far), plus the single output slot.
  bit          m_in   = 0;
  int          m_g    = 0;
  int          m_cnt  = 0;
  int          m_ptr  = 0;
  bit          m_ov   = 0;
  logic [31:0] m_od   = '0;
  bit          m_tr   = 0;

  logic [NS-1:0] obs_rdy, exp_rdy;
  logic          obs_ov;
  logic [31:0]   obs_od;

  // One clock: sample combinational/pre-edge view, advance model, settle.
  task automatic tick();
    bit acc;
    bit found;
    int idx;
    @(negedge clk);
    obs_rdy = src_ready;
    obs_ov  = out_valid;
    obs_od  = out_data;
    exp_rdy = (m_in && (!m_ov || out_ready)) ? NS'(1 << m_g) : '0;
    acc     = m_in && (!m_ov || out_ready) && src_valid[m_g];
    @(posedge clk);
    if (reset) begin
      m_in = 0; m_g = 0; m_cnt = 0; m_ptr = 0; m_ov = 0; m_od = '0; m_tr = 0;
    end else begin
      m_tr = 0;
      if (acc) begin
        m_od = {4'hF, src_data[PW*m_g +: PW], 4'(m_cnt)};
        m_ov = 1;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (!m_in) begin
        found = 0;
        for (int k = 1; k <= NS; k++) begin
          idx = (m_ptr + k) % NS;
          if (!found && src_valid[idx]) begin
            found = 1; m_g = idx; m_in = 1; m_cnt = 0;
          end
        end
      end else if (acc) begin
        if (src_last[m_g] || m_cnt == 15) begin
          m_tr  = (m_cnt == 15) && !src_last[m_g];
          m_in  = 0;
          m_ptr = m_g;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1; src_valid = '0; src_last = '0; out_ready = 1; src_data = '0;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; src_valid = 4'hF; src_last = '0; out_ready = 1;
    src_data = {$urandom, $urandom, $urandom};
    tick();
    tick();
    total++;
    if ({out_valid, src_ready, grant_id, busy} !== 8'b0) begin
      bad++;
      $display("FAIL reset_state act ov=%b rdy=%b gid=%0d busy=%b req all zero",
               out_valid, src_ready, grant_id, busy);
    end
    reset = 0;
    tick();
    total++;
    if ({grant_id, busy} !== {2'd1, 1'b1}) begin
      bad++;
      $display("FAIL reset_first_grant act gid=%0d busy=%b req gid=1 busy=1", grant_id, busy);
    end
    total++;
    if ({out_valid, out_data, grant_id, busy, trunc_err} !== {m_ov, m_od, SW'(m_g), m_in, m_tr}) begin
      bad++;
      $display("FAIL reset_model act %b/%h/%0d/%b/%b req %b/%h/%0d/%b/%b", out_valid, out_data,
               grant_id, busy, trunc_err, m_ov, m_od, m_g, m_in, m_tr);
    end
  endtask

  task automatic test_single();
    logic [PW-1:0] pays [3];
    logic [31:0]   expw [3];
    logic [31:0]   got[$];
    int w;
    pays = '{24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC};
    expw = '{32'hFAAAAAA0, 32'hFBBBBBB1, 32'hFCCCCCC2};
    do_reset();
    w = 0;
    for (int i = 0; i < 8; i++) begin
      src_valid = (w < 3) ? 4'b0100 : 4'b0000;
      src_data[PW*2 +: PW] = pays[(w < 3) ? w : 2];
      src_last  = (w == 2) ? 4'b0100 : 4'b0000;
      tick();
      if (exp_rdy[2] && src_valid[2]) w++;
      if (obs_ov && out_ready) got.push_back(obs_od);
      total++;
      if (obs_rdy !== exp_rdy) begin
        bad++; $display("FAIL single_ready act %b req %b", obs_rdy, exp_rdy);
      end
      total++;
      if ({out_valid, out_data, grant_id, busy, trunc_err} !== {m_ov, m_od, SW'(m_g), m_in, m_tr}) begin
        bad++;
        $display("FAIL single_model act %b/%h/%0d/%b/%b req %b/%h/%0d/%b/%b", out_valid, out_data,
                 grant_id, busy, trunc_err, m_ov, m_od, m_g, m_in, m_tr);
      end
    end
    total++;
    if (got.size() != 3) begin
      bad++; $display("FAIL single_count act %0d req 3", got.size());
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= got.size() || got[i] !== expw[i]) begin
        bad++;
        $display("FAIL single_word%0d act %h req %h", i, (i < got.size()) ? got[i] : 32'hx, expw[i]);
      end
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL single_busy_fall act %b req 0", busy);
    end
  endtask

  task automatic test_round_robin();
    logic [SW-1:0] order[$];
    int consec;
    bit prev_ov;
    do_reset();
    src_valid = 4'hF; src_last = 4'hF; out_ready = 1;
    consec = 0; prev_ov = 0;
    for (int i = 0; i < 24; i++) begin
      src_data = {$urandom, $urandom, $urandom};
      tick();
      total++;
      if (obs_rdy !== exp_rdy) begin
        bad++; $display("FAIL rr_ready act %b req %b", obs_rdy, exp_rdy);
      end
      total++;
      if ({out_valid, out_data, grant_id, busy, trunc_err} !== {m_ov, m_od, SW'(m_g), m_in, m_tr}) begin
        bad++;
        $display("FAIL rr_model act %b/%h/%0d/%b/%b req %b/%h/%0d/%b/%b", out_valid, out_data,
                 grant_id, busy, trunc_err, m_ov, m_od, m_g, m_in, m_tr);
      end
      if (out_valid) begin
        order.push_back(grant_id);
        total++;
        if (out_data[3:0] !== 4'h0) begin
          bad++; $display("FAIL rr_seq act %h req 0", out_data[3:0]);
        end
        if (prev_ov) consec++;
      end
      prev_ov = out_valid;
    end
    total++;
    if (order.size() < 8 || consec != 0) begin
      bad++; $display("FAIL rr_bubble act words=%0d back2back=%0d req >=8 and 0", order.size(), consec);
    end
    foreach (order[i]) begin
      total++;
      if (order[i] !== SW'((i + 1) % NS)) begin
        bad++; $display("FAIL rr_order%0d act %0d req %0d", i, order[i], (i + 1) % NS);
      end
    end
  endtask

  task automatic test_truncation();
    logic [31:0] got[$];
    int w, ntr;
    logic [31:0] req;
    do_reset();
    out_ready = 1; src_last = '0; w = 0; ntr = 0;
    for (int i = 0; i < 40; i++) begin
      src_valid = (w < 20) ? 4'b0001 : 4'b0000;
      src_data[0 +: PW] = 24'hA50000 | PW'(w);
      tick();
      if (exp_rdy[0] && src_valid[0]) w++;
      if (obs_ov && out_ready) got.push_back(obs_od);
      if (trunc_err) ntr++;
      total++;
      if ({out_valid, out_data, grant_id, busy, trunc_err} !== {m_ov, m_od, SW'(m_g), m_in, m_tr}) begin
        bad++;
        $display("FAIL trunc_model act %b/%h/%0d/%b/%b req %b/%h/%0d/%b/%b", out_valid, out_data,
                 grant_id, busy, trunc_err, m_ov, m_od, m_g, m_in, m_tr);
      end
    end
    total++;
    if (ntr != 1) begin
      bad++; $display("FAIL trunc_pulses act %0d req 1", ntr);
    end
    total++;
    if (got.size() != 20) begin
      bad++; $display("FAIL trunc_count act %0d req 20", got.size());
    end
    for (int j = 0; j < 20; j++) begin
      req = {4'hF, 24'hA50000 | PW'(j), 4'(j % 16)};
      total++;
      if (j >= got.size() || got[j] !== req) begin
        bad++;
        $display("FAIL trunc_word%0d act %h req %h", j, (j < got.size()) ? got[j] : 32'hx, req);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] sent[$];
    logic [31:0] got[$];
    logic [31:0] prev_od;
    bit prev_ov;
    int w;
    do_reset();
    w = 0;
    for (int i = 0; i < 30; i++) begin
      out_ready = !(i >= 5 && i < 10);
      src_valid = (w < 8) ? 4'b1000 : 4'b0000;
      src_last  = (w == 7) ? 4'b1000 : 4'b0000;
      src_data[PW*3 +: PW] = PW'($urandom);
      prev_ov = out_valid;
      prev_od = out_data;
      tick();
      if (exp_rdy[3] && src_valid[3]) begin
        sent.push_back({4'hF, src_data[PW*3 +: PW], 4'(w)});
        w++;
      end
      if (obs_ov && out_ready) got.push_back(obs_od);
      if (!out_ready && prev_ov) begin
        total++;
        if (out_data !== prev_od || out_valid !== 1'b1 || obs_rdy !== 4'b0) begin
          bad++;
          $display("FAIL stall_hold act %h/%b/%b req %h/1/0000", out_data, out_valid, obs_rdy, prev_od);
        end
      end
      total++;
      if (obs_rdy !== exp_rdy) begin
        bad++; $display("FAIL stall_ready act %b req %b", obs_rdy, exp_rdy);
      end
      total++;
      if ({out_valid, out_data, grant_id, busy, trunc_err} !== {m_ov, m_od, SW'(m_g), m_in, m_tr}) begin
        bad++;
        $display("FAIL stall_model act %b/%h/%0d/%b/%b req %b/%h/%0d/%b/%b", out_valid, out_data,
                 grant_id, busy, trunc_err, m_ov, m_od, m_g, m_in, m_tr);
      end
    end
    total++;
    if (got.size() != 8 || sent.size() != 8) begin
      bad++; $display("FAIL stall_count act got=%0d sent=%0d req 8", got.size(), sent.size());
    end
    for (int j = 0; j < 8; j++) begin
      total++;
      if (j >= got.size() || j >= sent.size() || got[j] !== sent[j]) begin
        bad++;
        $display("FAIL stall_word%0d act %h req %h", j, (j < got.size()) ? got[j] : 32'hx,
                 (j < sent.size()) ? sent[j] : 32'hx);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int w, n;
    do_reset();
    src_valid = 4'b0010; src_last = '0; out_ready = 1; w = 0; n = 0;
    while (w < 2 && n < 20) begin
      src_data[PW +: PW] = 24'h100000 | PW'(w);
      tick();
      if (exp_rdy[1] && src_valid[1]) w++;
      n++;
    end
    total++;
    if (w < 2) begin
      bad++; $display("FAIL rstmid_timeout act words=%0d req 2", w);
    end
    reset = 1;
    src_data[PW +: PW] = 24'h100002;
    tick();
    total++;
    if ({out_valid, busy} !== 2'b00) begin
      bad++; $display("FAIL rstmid_drop act ov=%b busy=%b req 0 0", out_valid, busy);
    end
    reset = 0;
    tick();
    tick();
    total++;
    if ({out_valid, out_data} !== {1'b1, 4'hF, 24'h100002, 4'h0}) begin
      bad++; $display("FAIL rstmid_restart act %b/%h req 1/f1000020", out_valid, out_data);
    end
    total++;
    if ({out_valid, out_data, grant_id, busy, trunc_err} !== {m_ov, m_od, SW'(m_g), m_in, m_tr}) begin
      bad++;
      $display("FAIL rstmid_model act %b/%h/%0d/%b/%b req %b/%h/%0d/%b/%b", out_valid, out_data,
               grant_id, busy, trunc_err, m_ov, m_od, m_g, m_in, m_tr);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset     = (($urandom % 64) == 0);
      src_valid = NS'($urandom);
      src_last  = NS'($urandom & $urandom & $urandom);
      src_data  = {$urandom, $urandom, $urandom};
      out_ready = (($urandom % 4) != 0);
      tick();
      total++;
      if (obs_rdy !== exp_rdy) begin
        bad++; $display("FAIL rand_ready cyc=%0d act %b req %b", i, obs_rdy, exp_rdy);
      end
      total++;
      if ({out_valid, out_data, grant_id, busy, trunc_err} !== {m_ov, m_od, SW'(m_g), m_in, m_tr}) begin
        bad++;
        $display("FAIL rand_model cyc=%0d act %b/%h/%0d/%b/%b req %b/%h/%0d/%b/%b", i, out_valid,
                 out_data, grant_id, busy, trunc_err, m_ov, m_od, m_g, m_in, m_tr);
      end
    end
    reset = 0;
  endtask

  initial begin
    reset = 1; src_valid = '0; src_last = '0; src_data = '0; out_ready = 1;
    test_reset();
    test_single();
    test_round_robin();
    test_truncation();
    test_stall();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
